key_expander: RTL and testbench

// - Iterative AES key-expansion engine. Expands a 128- or 256-bit cipher key into NR+1 round keys,
//   one 32-bit word per clock, and holds them in an internal round-key store.
// - Serves round keys to the encrypt/decrypt round datapath, indexed by round counter, in forward or reverse order.
// - Supersedes the fixed 128-bit, fully combinational key schedule. Adds AES-256, load/busy/valid handshake,

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/key_expander_if.sv | 32 +++
 rtl/key_expander_sub_word.sv | 14 +
 rtl/key_expander.sv | 178 +++++++++++++++++
 tb/tb_key_expander.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, types and helper functions
//
// Purpose: S-box and round-constant tables, word/round-key types and the
// key-expansion FSM state encoding shared by the key expander and its
// sub-modules.
// Ports: none (package).

package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Index 0 and anything above 10 have no round constant; return 0 there
    // so an out-of-range counter can never select past the table.
    function automatic logic [7:0] rcon(input logic [3:0] n);
        if (n >= 4'd1 && n <= 4'd10) begin
            return RCON[n];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/key_expander_if.sv
// rtl/key_expander_if.sv - key expander load/readout bundle
//
// Purpose: groups the key-load handshake and round-key readout signals.
// Signals: key_load, key_in[32*NK], clear, decrypt_mode, round_idx[4]
// (master -> slave); round_key[128], busy, key_valid (slave -> master).

interface key_expander_if
    import aes_pkg::*;
#(
    parameter int NK = 4
);
    localparam int KEY_W = 32 * NK;

    logic             key_load;
    logic [KEY_W-1:0] key_in;
    logic             clear;
    logic             decrypt_mode;
    logic [3:0]       round_idx;
    rkey_t            round_key;
    logic             busy;
    logic             key_valid;

    modport master (
        output key_load, key_in, clear, decrypt_mode, round_idx,
        input  round_key, busy, key_valid
    );

    modport slave (
        input  key_load, key_in, clear, decrypt_mode, round_idx,
        output round_key, busy, key_valid
    );
endinterface

// File: rtl/key_expander_sub_word.sv
// rtl/key_expander_sub_word.sv - AES SubWord, four parallel S-box lookups
//
// Purpose: combinational byte-wise S-box substitution of a 32-bit word.
// Ports: value[32] in, result[32] out.

module sub_word
    import aes_pkg::*;
(
    input  word_t value,
    output word_t result
);
    assign result = {sbox(value[31:24]), sbox(value[23:16]),
                     sbox(value[15:8]),  sbox(value[7:0])};
endmodule

// File: rtl/key_expander.sv
// rtl/key_expander.sv - iterative AES-128/256 key expansion with round-key store
//
// Purpose: expands a 4- or 8-word cipher key one word per clock into NR+1
// round keys, holds them, and serves them by round index in encrypt or
// decrypt order.
// Ports: clk, n_rst (async active-low), bus (key_expander_if.slave):
// key_load/key_in start expansion, clear zeroizes, decrypt_mode/round_idx
// select round_key, busy/key_valid report progress.

module key_expander
    import aes_pkg::*;
#(
    parameter int NK = 4
)
(
    input  logic          clk,
    input  logic          n_rst,
    key_expander_if.slave bus
);
    localparam int NR     = NK + 6;
    localparam int KEY_W  = 32 * NK;
    localparam int NWORDS = 4 * (NR + 1);

    localparam logic [5:0] FIRST_WORD = 6'(NK);
    localparam logic [5:0] LAST_WORD  = 6'(NWORDS - 1);
    localparam logic [2:0] LAST_POS   = 3'(NK - 1);
    localparam logic [3:0] NR_IDX     = 4'(NR);

    if (NK != 4 && NK != 8) begin : g_bad_nk
        $fatal(1, "key_expander: NK must be 4 or 8");
    end

    state_t state;
    state_t next_state;

    // word_idx is i; word_pos/round_num track i%NK and i/NK incrementally
    // so no divider is needed.
    logic [5:0] word_idx;
    logic [2:0] word_pos;
    logic [3:0] round_num;

    // window[0] = w[i-NK] ... window[NK-1] = w[i-1]
    word_t window [NK];
    rkey_t store  [NR+1];

    logic  step;
    logic  busy;
    logic  key_valid;
    word_t prev_word;
    word_t sub_in;
    word_t sub_out;
    word_t temp_word;
    word_t new_word;
    logic [3:0] rd_idx;
    rkey_t      rd_key;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        key_valid  = 1'b0;
        case (state)
            ST_IDLE:   ;
            ST_EXPAND: busy      = 1'b1;
            ST_DONE:   key_valid = 1'b1;
            default:   ;
        endcase
        // clear beats key_load; key_load restarts from any state.
        if (bus.clear) begin
            next_state = ST_IDLE;
        end else if (bus.key_load) begin
            next_state = ST_EXPAND;
        end else if (state == ST_EXPAND && word_idx == LAST_WORD) begin
            next_state = ST_DONE;
        end
    end

    assign step = (state == ST_EXPAND) && !bus.clear && !bus.key_load;

    // ----------------------------------------------------------- counters
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_idx  <= '0;
            word_pos  <= '0;
            round_num <= '0;
        end else if (bus.clear) begin
            word_idx  <= '0;
            word_pos  <= '0;
            round_num <= '0;
        end else if (bus.key_load) begin
            word_idx  <= FIRST_WORD;
            word_pos  <= '0;
            round_num <= 4'd1;
        end else if (step) begin
            word_idx <= word_idx + 6'd1;
            if (word_pos == LAST_POS) begin
                word_pos  <= '0;
                round_num <= round_num + 4'd1;
            end else begin
                word_pos <= word_pos + 3'd1;
            end
        end
    end

    // --------------------------------------------------------- recurrence
    assign prev_word = window[NK-1];
    // RotWord only feeds the S-box at word_pos 0; the AES-256 mid-key
    // substitution at word_pos 4 uses the unrotated word.
    assign sub_in = (word_pos == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    sub_word u_sub_word (
        .value  (sub_in),
        .result (sub_out)
    );

    always_comb begin
        temp_word = prev_word;
        if (word_pos == 3'd0) begin
            temp_word = sub_out ^ {rcon(round_num), 24'h0};
        end else if (NK == 8 && word_pos == 3'd4) begin
            temp_word = sub_out;
        end
        new_word = window[0] ^ temp_word;
    end

    // -------------------------------------------------------- window/store
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NK; k++) window[k] <= '0;
            for (int r = 0; r <= NR; r++) store[r] <= '0;
        end else if (bus.clear) begin
            for (int k = 0; k < NK; k++) window[k] <= '0;
            for (int r = 0; r <= NR; r++) store[r] <= '0;
        end else if (bus.key_load) begin
            for (int k = 0; k < NK; k++) begin
                window[k] <= bus.key_in[KEY_W-1-32*k -: 32];
            end
            store[0] <= bus.key_in[KEY_W-1 -: 128];
            if (NK == 8) begin
                store[1] <= bus.key_in[127:0];
            end
        end else if (step) begin
            for (int k = 0; k < NK - 1; k++) window[k] <= window[k+1];
            window[NK-1] <= new_word;
            // word i lands in round key i/4, slot i%4 (slot 0 is the MSW)
            case (word_idx[1:0])
                2'd0:    store[word_idx[5:2]][127:96] <= new_word;
                2'd1:    store[word_idx[5:2]][95:64]  <= new_word;
                2'd2:    store[word_idx[5:2]][63:32]  <= new_word;
                default: store[word_idx[5:2]][31:0]   <= new_word;
            endcase
        end
    end

    // ------------------------------------------------------------ readout
    // The subtraction is only formed for in-range indices, so it never wraps.
    always_comb begin
        rd_idx = '0;
        rd_key = '0;
        if (key_valid && bus.round_idx <= NR_IDX) begin
            rd_idx = bus.decrypt_mode ? (NR_IDX - bus.round_idx) : bus.round_idx;
            rd_key = store[rd_idx];
        end
    end

    assign bus.round_key = rd_key;
    assign bus.busy      = busy;
    assign bus.key_valid = key_valid;

endmodule

// File: tb/tb_key_expander.sv
// tb/tb_key_expander.sv - directed self-checking bench for key_expander

module tb_key_expander;

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K128_1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K128_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_E = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] KA     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KZ_1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KZ_A   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    key_expander_if #(.NK(4)) bus128 ();
    key_expander_if #(.NK(8)) bus256 ();

    key_expander #(.NK(4)) u_dut128 (.clk(clk), .n_rst(n_rst), .bus(bus128));
    key_expander #(.NK(8)) u_dut256 (.clk(clk), .n_rst(n_rst), .bus(bus256));

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load128(input logic [127:0] key);
        @(negedge clk);
        bus128.key_in   = key;
        bus128.key_load = 1'b1;
        @(negedge clk);
        bus128.key_load = 1'b0;
    endtask

    task automatic load256(input logic [255:0] key);
        @(negedge clk);
        bus256.key_in   = key;
        bus256.key_load = 1'b1;
        @(negedge clk);
        bus256.key_load = 1'b0;
    endtask

    // Counts negedges after the load edge until key_valid rises (bounded).
    task automatic wait_valid(input int sel, output int cycles);
        cycles = 0;
        while (((sel == 0) ? bus128.key_valid : bus256.key_valid) !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic rk128(input string tag, input logic dec, input logic [3:0] idx, input logic [127:0] exp);
        bus128.decrypt_mode = dec;
        bus128.round_idx    = idx;
        #1;
        check(tag, bus128.round_key, exp);
    endtask

    task automatic rk256(input string tag, input logic dec, input logic [3:0] idx, input logic [127:0] exp);
        bus256.decrypt_mode = dec;
        bus256.round_idx    = idx;
        #1;
        check(tag, bus256.round_key, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0;
        bus128.key_load = 1'b0; bus128.key_in = '0; bus128.clear = 1'b0;
        bus128.decrypt_mode = 1'b0; bus128.round_idx = '0;
        bus256.key_load = 1'b0; bus256.key_in = '0; bus256.clear = 1'b0;
        bus256.decrypt_mode = 1'b0; bus256.round_idx = '0;

        #12;
        check("rst busy128",  128'(bus128.busy),      128'd0);
        check("rst valid128", 128'(bus128.key_valid), 128'd0);
        check("rst rk128",    bus128.round_key,       128'd0);
        check("rst valid256", 128'(bus256.key_valid), 128'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // AES-128 expansion
        load128(K128);
        check("busy128 start", 128'(bus128.busy), 128'd1);
        wait_valid(0, cyc);
        check("latency128", 128'(cyc), 128'd40);
        check("busy128 done", 128'(bus128.busy), 128'd0);
        rk128("enc rk0",  1'b0, 4'd0,  K128);
        rk128("enc rk1",  1'b0, 4'd1,  K128_1);
        rk128("enc rk10", 1'b0, 4'd10, K128_A);
        rk128("enc rk15", 1'b0, 4'd15, 128'd0);
        rk128("dec rk0",  1'b1, 4'd0,  K128_A);
        rk128("dec rk9",  1'b1, 4'd9,  K128_1);
        rk128("dec rk10", 1'b1, 4'd10, K128);
        rk128("dec rk11", 1'b1, 4'd11, 128'd0);

        // AES-256 expansion
        load256(K256);
        wait_valid(1, cyc);
        check("latency256", 128'(cyc), 128'd52);
        rk256("256 enc rk0",  1'b0, 4'd0,  K256[255:128]);
        rk256("256 enc rk1",  1'b0, 4'd1,  K256[127:0]);
        rk256("256 enc rk14", 1'b0, 4'd14, K256_E);
        rk256("256 dec rk0",  1'b1, 4'd0,  K256_E);
        rk256("256 dec rk14", 1'b1, 4'd14, K256[255:128]);
        rk256("256 enc rk15", 1'b0, 4'd15, 128'd0);

        // Restart: key A, then the all-zero key 20 cycles after A's load edge
        load128(KA);
        repeat (18) @(negedge clk);
        check("restart mid valid", 128'(bus128.key_valid), 128'd0);
        load128(128'd0);
        wait_valid(0, cyc);
        check("restart latency", 128'(cyc), 128'd40);
        rk128("restart rk0",  1'b0, 4'd0,  128'd0);
        rk128("restart rk1",  1'b0, 4'd1,  KZ_1);
        rk128("restart rk10", 1'b0, 4'd10, KZ_A);

        // clear and key_load on the same edge while in DONE
        @(negedge clk);
        bus128.clear    = 1'b1;
        bus128.key_load = 1'b1;
        bus128.key_in   = K128;
        @(negedge clk);
        bus128.clear    = 1'b0;
        bus128.key_load = 1'b0;
        check("clear busy",  128'(bus128.busy),      128'd0);
        check("clear valid", 128'(bus128.key_valid), 128'd0);
        for (int i = 0; i < 16; i++) begin
            rk128("clear rk", 1'b0, 4'(i), 128'd0);
        end
        repeat (3) @(negedge clk);
        check("clear idle busy", 128'(bus128.busy), 128'd0);

        // Asynchronous reset in the middle of an expansion
        bus256.decrypt_mode = 1'b0;
        bus256.round_idx    = 4'd14;
        load128(K128);
        repeat (10) @(negedge clk);
        #2;
        check("pre-rst busy", 128'(bus128.busy), 128'd1);
        n_rst = 1'b0;
        #1;
        check("arst busy128",  128'(bus128.busy),      128'd0);
        check("arst valid128", 128'(bus128.key_valid), 128'd0);
        check("arst rk128",    bus128.round_key,       128'd0);
        check("arst valid256", 128'(bus256.key_valid), 128'd0);
        check("arst rk256",    bus256.round_key,       128'd0);
        @(negedge clk);
        n_rst = 1'b1;
        load128(K128);
        wait_valid(0, cyc);
        check("post-rst latency", 128'(cyc), 128'd40);
        rk128("post-rst rk1",  1'b0, 4'd1,  K128_1);
        rk128("post-rst rk10", 1'b0, 4'd10, K128_A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
